// File: rtl/neuro_pkg.sv
// Shared widths, the AER event record and the handshake FSM state encoding
// for the spike-to-AER encoder.
package neuro_pkg;
  localparam int NEUR_ADDR_LEN = 8;
  localparam int TS_LEN        = 16;

  typedef struct packed {
    logic [TS_LEN-1:0]        ts;
    logic [NEUR_ADDR_LEN-1:0] addr;
  } aer_event_t;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    REQ          = 2'd1,
    WAIT_ACK_LOW = 2'd2
  } aer_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read/write pointers; the head entry is
// always visible on pop_data so the consumer can load it on the popping edge.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
endmodule

// File: rtl/spike_aer_encoder.sv
// Stamps neuron spikes with the current timestep, buffers them and offers them
// one at a time over a four-phase AER req/ack link.
module spike_aer_encoder #(
  parameter int NEUR_ADDR_LEN = neuro_pkg::NEUR_ADDR_LEN,
  parameter int TS_LEN        = neuro_pkg::TS_LEN,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     spike_valid,
  input  logic                     spike_in,
  input  logic [NEUR_ADDR_LEN-1:0] spike_addr,
  input  logic                     dt_tick,
  output logic                     aer_req,
  input  logic                     aer_ack,
  output logic [NEUR_ADDR_LEN-1:0] aer_addr,
  output logic [TS_LEN-1:0]        aer_ts,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);
  import neuro_pkg::*;

  localparam int EW = TS_LEN + NEUR_ADDR_LEN;

  aer_state_t               state_q, state_d;
  logic [TS_LEN-1:0]        ts_q, ts_d;
  logic                     cap_valid_q, cap_valid_d;
  logic [EW-1:0]            cap_event_q, cap_event_d;
  logic                     aer_req_q, aer_req_d;
  logic [NEUR_ADDR_LEN-1:0] aer_addr_q, aer_addr_d;
  logic [TS_LEN-1:0]        aer_ts_q, aer_ts_d;
  logic                     overflow_q, overflow_d;
  logic [7:0]               drop_cnt_q, drop_cnt_d;
  logic                     fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
  logic [EW-1:0]            fifo_head;

  // Spikes are registered first so no input reaches the FIFO flags combinationally.
  always_comb begin
    ts_d        = ts_q + TS_LEN'(dt_tick);
    cap_valid_d = spike_valid && spike_in;
    cap_event_d = cap_event_q;
    if (spike_valid && spike_in) begin
      cap_event_d = {ts_q, spike_addr};
    end
    drop       = cap_valid_q && fifo_full && !fifo_pop;
    fifo_push  = cap_valid_q && !drop;
    overflow_d = overflow_q || drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    aer_req_d  = aer_req_q;
    aer_addr_d = aer_addr_q;
    aer_ts_d   = aer_ts_q;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !aer_ack) begin
          fifo_pop   = 1'b1;
          aer_addr_d = fifo_head[NEUR_ADDR_LEN-1:0];
          aer_ts_d   = fifo_head[EW-1:NEUR_ADDR_LEN];
          aer_req_d  = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (aer_ack) begin
          aer_req_d = 1'b0;
          state_d   = WAIT_ACK_LOW;
        end
      end
      WAIT_ACK_LOW: begin
        // Once ack is low the link is idle; start the next event on the same
        // edge rather than spending a cycle in IDLE.
        if (!aer_ack) begin
          state_d = IDLE;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            aer_addr_d = fifo_head[NEUR_ADDR_LEN-1:0];
            aer_ts_d   = fifo_head[EW-1:NEUR_ADDR_LEN];
            aer_req_d  = 1'b1;
            state_d    = REQ;
          end
        end
      end
      default: begin
        aer_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ts_q        <= '0;
      cap_valid_q <= 1'b0;
      cap_event_q <= '0;
      aer_req_q   <= 1'b0;
      aer_addr_q  <= '0;
      aer_ts_q    <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ts_q        <= ts_d;
      cap_valid_q <= cap_valid_d;
      cap_event_q <= cap_event_d;
      aer_req_q   <= aer_req_d;
      aer_addr_q  <= aer_addr_d;
      aer_ts_q    <= aer_ts_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (cap_event_q),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign aer_req  = aer_req_q;
  assign aer_addr = aer_addr_q;
  assign aer_ts   = aer_ts_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
endmodule

// File: doc/spike_aer_encoder.md
SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

Interface
REQ-001 Parameter NEUR_ADDR_LEN, default 8: width of the neuron address carried with each spike.
REQ-002 Parameter TS_LEN, default 16: width of the timestep stamp.
REQ-003 Parameter FIFO_DEPTH, default 16: event buffer depth, a power of 2, at least 2.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port spike_valid, input, 1: spike_in and spike_addr are valid this cycle (one slot of the time-multiplexed neuron update).
REQ-007 Port spike_in, input, 1: the neuron in this slot spiked.
REQ-008 Port spike_addr, input, NEUR_ADDR_LEN: index of the neuron in this slot.
REQ-009 Port dt_tick, input, 1: one-cycle pulse marking the end of a timestep dT.
REQ-010 Port aer_req, output, 1: four-phase AER request.
REQ-011 Port aer_ack, input, 1: four-phase AER acknowledge from the receiver.
REQ-012 Port aer_addr, output, NEUR_ADDR_LEN: address of the event on offer.
REQ-013 Port aer_ts, output, TS_LEN: timestep stamp of the event on offer.
REQ-014 Port overflow, output, 1: sticky flag, at least one event dropped since reset.
REQ-015 Port drop_cnt, output, 8: count of dropped events, saturating at 255.

Function
REQ-016 The timestamp counter SHALL increment by 1 on each cycle with dt_tick=1 and wrap modulo 2^TS_LEN.
REQ-017 An event SHALL be captured on every edge where spike_valid=1 and spike_in=1, as {timestamp counter value before any same-cycle increment, spike_addr}.
REQ-018 A captured event SHALL be written to the FIFO unless the FIFO is full and no pop occurs on the same edge.
REQ-019 A push on the same edge as a pop SHALL be accepted even when the FIFO is full.
REQ-020 A rejected event SHALL set overflow and increment drop_cnt, saturating at 255; FIFO contents SHALL be unchanged.
REQ-021 Events SHALL leave in strict FIFO order; none SHALL be duplicated or reordered.
REQ-022 The FSM SHALL have states IDLE, REQ and WAIT_ACK_LOW.
REQ-023 IDLE, FIFO non-empty, aer_ack=0: pop the head, register it onto aer_addr and aer_ts, set aer_req=1, go to REQ.
REQ-024 IDLE with aer_ack=1 SHALL NOT start a transfer.
REQ-025 REQ: hold aer_req, aer_addr and aer_ts stable; when aer_ack=1, clear aer_req and go to WAIT_ACK_LOW.
REQ-026 WAIT_ACK_LOW: when aer_ack=0, go to IDLE.
REQ-027 Latency: a spike sampled at edge E0 into an empty FIFO with the FSM in IDLE and aer_ack=0 SHALL raise aer_req after edge E0+2.
REQ-028 Back-to-back events SHALL achieve at least one transfer per 4 cycles when aer_ack responds in 1 cycle.
REQ-029 aer_addr and aer_ts SHALL be driven from registers; no combinational path from any input to any output.

Reset
REQ-030 Reset SHALL empty the FIFO, set state to IDLE and clear timestamp, aer_req, aer_addr, aer_ts, overflow and drop_cnt to 0.
REQ-031 Reset asserted mid-handshake SHALL drop aer_req on the next edge and abandon the in-flight event without counting it as a drop.
REQ-032 spike_valid and dt_tick SHALL be ignored on reset edges.

Structure
REQ-033 Package neuro_pkg SHALL hold NEUR_ADDR_LEN, TS_LEN, typedef aer_event_t {ts, addr}, and the FSM state enum.
REQ-034 Buffering SHALL be a sub-module sync_fifo (parameterised width and depth, push/pop/full/empty, registered pointers); the FSM and timestamp logic SHALL stay in spike_aer_encoder.

Verification
REQ-035 Single event: ts=5, spike at addr 0x2A, aer_ack tied to aer_req with 1-cycle delay -> aer_req rises 2 cycles after the spike; aer_addr=0x2A, aer_ts=5; exactly one handshake.
REQ-036 Burst: 20 consecutive spikes, addrs 0..19, FIFO_DEPTH=16, aer_ack held 0 -> first 17 accepted (16 buffered plus 1 in flight), overflow=1, drop_cnt=3; after aer_ack is released, addrs 0..16 emerge in order.
REQ-037 Tick race: dt_tick and spike on the same edge with ts=7 -> event carries ts=7; the next spike carries ts=8.
REQ-038 Wrap: 2^TS_LEN dt_ticks from reset, then a spike -> aer_ts=0.
REQ-039 Reset in REQ with an event on offer and 3 buffered -> aer_req=0 after the next edge, no further events, overflow=0, drop_cnt=0.
REQ-040 Saturation: 300 rejected spikes -> drop_cnt=255, overflow=1.
